// File: rtl/stage_buf_pkg.sv
// rtl/stage_buf_pkg.sv - shared types and default sizes for the NTT stage data buffer
// Purpose: load-controller state encoding and default geometry used by stage_data_buf.
// Ports: none (package).
package stage_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } stage_state_e;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_NUM_PORTS = 4;

endpackage

// File: rtl/stage_buf_load_ctrl.sv
// rtl/stage_buf_load_ctrl.sv - streaming load FSM and fill counter for the stage data buffer
// Purpose: sequences IDLE/LOAD/RUN, generates RAM fill writes and the load_done pulse.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   sen_i            stage enable; 0 freezes state, counter and load_done
//   load_start_i     start/restart a load (ignored while loading)
//   in_valid_i       load stream beat valid
//   in_ready_o       high while in LOAD
//   load_done_o      one-cycle pulse after the last word is written
//   load_we_o        RAM fill write strobe
//   load_addr_o      RAM fill address (fill counter)
//   state_o          current state, used by the top to gate port access
module stage_buf_load_ctrl
    import stage_buf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen_i,
    input  logic              load_start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              load_done_o,
    output logic              load_we_o,
    output logic [ADDR_W-1:0] load_addr_o,
    output stage_state_e      state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    stage_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        load_we_o = 1'b0;
        if (sen_i) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        load_we_o = 1'b1;
                        // The counter wraps to 0 naturally on the last word.
                        cnt_d     = cnt_q + ADDR_W'(1);
                        if (cnt_q == LAST_ADDR) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_start_i) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == LOAD);
    assign load_done_o = done_q;
    assign load_addr_o = cnt_q;
    assign state_o     = state_q;

endmodule

// File: rtl/stage_data_buf.sv
// rtl/stage_data_buf.sv - multi-port coefficient RAM with streaming load for the NTT datapath
// Purpose: NUM_PORTS read and write ports on one DEPTH x DATA_W RAM, read-first,
//   lowest-index write wins on collisions, plus a streaming fill phase.
// Optional feature macro: STAGE_BUF_OUT_REG_EN adds an output register (read latency 2).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   SEN                      stage enable; 0 freezes state, RAM and outputs
//   load_start, in_valid,
//   in_data, in_ready,
//   load_done                streaming load interface
//   SREN, rd_addr            per-port read enable / packed read addresses
//   rd_data, rd_valid        packed read data / per-port valid
//   wr_en, wr_addr, wr_data  per-port write enable / packed addresses / packed data
//   wr_conflict              pulse: two or more ports wrote one address last cycle
module stage_data_buf
    import stage_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SEN,
    input  logic                        load_start,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        load_done,
    input  logic [NUM_PORTS-1:0]        SREN,
    input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_PORTS*DATA_W-1:0] rd_data,
    output logic [NUM_PORTS-1:0]        rd_valid,
    input  logic [NUM_PORTS-1:0]        wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic                        wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    stage_state_e      state;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic              port_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                        conflict_d;
    logic                        wr_conflict_q;
    logic [NUM_PORTS*DATA_W-1:0] rd_data_q;
    logic [NUM_PORTS-1:0]        rd_valid_q;

    stage_buf_load_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_load_ctrl (
        .clk          (clk),
        .rst          (rst),
        .sen_i        (SEN),
        .load_start_i (load_start),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .load_done_o  (load_done),
        .load_we_o    (load_we),
        .load_addr_o  (load_addr),
        .state_o      (state)
    );

    // Port traffic is only honoured outside the load phase.
    assign port_ok = (state != LOAD);

    // Ports are scanned from highest to lowest index so the lowest-index
    // port's non-blocking write is scheduled last and wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst && SEN) begin
            if (load_we) begin
                mem[load_addr] <= in_data;
            end else if (port_ok) begin
                for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                    if (wr_en[p]) begin
                        mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (wr_en[p] && wr_en[q] &&
                    (wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[q*ADDR_W +: ADDR_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict_q <= 1'b0;
        end else if (SEN) begin
            wr_conflict_q <= conflict_d && port_ok;
        end
    end

    // Reads sample the RAM before this edge's writes land, giving read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else if (SEN) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_ok && SREN[p]) begin
                    rd_data_q[p*DATA_W +: DATA_W] <= mem[rd_addr[p*ADDR_W +: ADDR_W]];
                    rd_valid_q[p]                 <= 1'b1;
                end else begin
                    rd_valid_q[p] <= 1'b0;
                end
            end
        end
    end

`ifdef STAGE_BUF_OUT_REG_EN
    logic [NUM_PORTS*DATA_W-1:0] rd_data_q2;
    logic [NUM_PORTS-1:0]        rd_valid_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q2  <= '0;
            rd_valid_q2 <= '0;
        end else if (SEN) begin
            rd_data_q2  <= rd_data_q;
            rd_valid_q2 <= rd_valid_q;
        end
    end

    assign rd_data  = rd_data_q2;
    assign rd_valid = rd_valid_q2 & {NUM_PORTS{port_ok}};
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q & {NUM_PORTS{port_ok}};
`endif

    assign wr_conflict = wr_conflict_q;

endmodule
